tinyalu_arbiter: RTL and testbench
==================================

Name: tinyalu_arbiter

Overview:
- Shares one tinyalu instance between NUM_REQ independent requesters using round-robin arbitration.
- Sequences the ALU's start/done protocol: holds operands and op stable for the whole operation and guarantees a clean idle cycle between operations.
- Completes NOP requests locally and bounds every operation with a timeout.
- Sits between requester agents and tinyalu in the same clock domain.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- TIMEOUT_CYCLES, 15: BUSY cycles without alu_done before the operation is aborted, 8..255.

Ports:
- clk_i  in  1  clock, rising edge
- reset_i  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request pending
- req_ready  out  NUM_REQ  one-hot acceptance strobe
- req_a  in  8*NUM_REQ  operand A, requester i at [8i+7:8i]
- req_b  in  8*NUM_REQ  operand B, same packing as req_a
- req_op  in  3*NUM_REQ  opcode, requester i at [3i+2:3i]
- rsp_valid  out  NUM_REQ  one-cycle response pulse to the owning requester
- rsp_result  out  16  result, valid with any rsp_valid bit
- rsp_err  out  1  timeout flag, valid with rsp_valid
- alu_a  out  8  drives tinyalu A
- alu_b  out  8  drives tinyalu B
- alu_op  out  3  drives tinyalu op
- alu_start  out  1  drives tinyalu start
- alu_reset_n  out  1  combinational ~reset_i, drives tinyalu reset_n
- alu_done  in  1  tinyalu done
- alu_result  in  16  tinyalu result

Behaviour:
- States: IDLE, BUSY, RESP.
- Reset values: state=IDLE; rr pointer=0 (requester 0 highest priority); alu_a/alu_b/alu_op/alu_start=0; req_ready=0; rsp_valid=0; rsp_result=0; rsp_err=0; timeout counter=0.
- Reset mid-operation: same values at the next edge; no rsp_valid is ever issued for the aborted request.
- IDLE arbitration:
  - Winner is the first asserted req_valid searching upward (with wrap) from the rr pointer.
  - req_ready[winner]=1, combinational in IDLE only.
  - On acceptance, latch A/B/op and the winner index, and set rr pointer = winner+1 mod NUM_REQ.
- IDLE, op==3'b000 (NOP): go to RESP with rsp_result=0 and rsp_err=0. The ALU is not started.
- IDLE, any other op: go to BUSY.
- BUSY:
  - alu_start=1; alu_a/alu_b/alu_op are held at the latched values for the whole state.
  - The timeout counter increments each cycle.
  - On alu_done=1: capture alu_result into rsp_result, rsp_err=0, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES with no alu_done: rsp_result=16'hFFFF, rsp_err=1, go to RESP.
- RESP:
  - alu_start=0 and rsp_valid[owner]=1 for exactly one cycle; no backpressure.
  - Then go to IDLE and clear the timeout counter.
  - The RESP cycle with start low flushes the ALU done pipeline, so alu_done is 0 in the following IDLE cycle.
- Latency, request accepted in cycle t:
  - NOP: rsp_valid at t+1.
  - op 001/010/011: alu_done at t+2, rsp_valid at t+3.
  - op[2]=1 (multiply, including 101..111): alu_done at t+5, rsp_valid at t+6.
- Throughput: a new request can be accepted in the IDLE cycle right after RESP.
  - Back-to-back ALU ops therefore have alu_start low for at least 2 cycles between them.
- Simultaneous events:
  - req_valid changing during BUSY/RESP has no effect.
  - A requester may reassert req_valid in the same cycle its rsp_valid is high; it is considered in the next IDLE.
- alu_done is ignored outside BUSY.
- Width rule: multiply result is the full 16 bits; add/and/xor results are zero-extended by the ALU and passed through unmodified.

Optional Feature:
- Macro: TINYALU_ARB_STATS_EN.
- Defined: adds outputs stat_ops (32-bit count of completed non-NOP responses), stat_busy (32-bit count of cycles in BUSY) and stat_timeouts (8-bit, saturating).
  - All three reset to 0 and increment on the same edge as the state transition.
  - The 32-bit counters wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single add: req0 with A=8'd200, B=8'd100, op=001 accepted at t -> rsp_valid[0] at t+3, rsp_result=16'd300, rsp_err=0.
- Multiply: req2 with A=8'hFF, B=8'hFF, op=100 -> rsp_valid[2] at t+6, rsp_result=16'hFE01; alu_start high exactly t+1..t+5.
- Round-robin: all 4 requesters assert continuously with op=010 -> grant order 0,1,2,3,0; each response matches its own A&B; no requester is granted twice before the others.
- NOP: req1 op=000 -> rsp_valid[1] at t+1, result 0, alu_start never asserted.
- Timeout: ALU model never asserts done, op=011 -> rsp_valid at t+1+TIMEOUT_CYCLES, rsp_result=16'hFFFF, rsp_err=1; next request then completes normally.
- Reset mid-multiply: reset_i asserted at t+3 -> the next cycle shows alu_start=0, state IDLE, no rsp_valid; a subsequent op=001 returns the correct sum.

Source files
------------

// File: rtl/tinyalu_arbiter.sv
// tinyalu_arbiter: round-robin sharing of one tinyalu among NUM_REQ requesters; TINYALU_ARB_STATS_EN adds stat counters
module tinyalu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  input  logic [3*NUM_REQ-1:0] req_op,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [15:0]          rsp_result,
  output logic                 rsp_err,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [2:0]           alu_op,
  output logic                 alu_start,
  output logic                 alu_reset_n,
  input  logic                 alu_done,
  input  logic [15:0]          alu_result
`ifdef TINYALU_ARB_STATS_EN
  ,
  output logic [31:0]          stat_ops,
  output logic [31:0]          stat_busy,
  output logic [7:0]           stat_timeouts
`endif
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
  state_t r_state, w_next;
  logic [PW-1:0] r_ptr, r_owner, w_win;
  logic [7:0] r_a, r_b, r_cnt;
  logic [2:0] r_op, w_op;
  logic [15:0] r_result;
  logic r_err, w_any, w_accept, w_nop, w_tmo;
  int w_idx;
  always_comb begin
    w_win = r_ptr;
    w_any = 1'b0;
    w_idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = int'(r_ptr) + k;
      w_idx = w_idx >= NUM_REQ ? w_idx - NUM_REQ : w_idx;
      if (req_valid[w_idx]) begin
        w_win = PW'(w_idx);
        w_any = 1'b1;
      end
    end
    w_op = req_op[3*int'(w_win) +: 3];
    w_nop = w_op == 3'b000;
    w_accept = r_state == S_IDLE && w_any;
    w_tmo = r_cnt == 8'(TIMEOUT_CYCLES - 1);
    w_next = r_state == S_IDLE ? (w_any ? (w_nop ? S_RESP : S_BUSY) : S_IDLE) :
             r_state == S_BUSY ? ((alu_done || w_tmo) ? S_RESP : S_BUSY) : S_IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a     <= req_a[8*int'(w_win) +: 8];
        r_b     <= req_b[8*int'(w_win) +: 8];
        r_op    <= w_op;
        r_owner <= w_win;
        r_ptr   <= w_win == PW'(NUM_REQ - 1) ? '0 : w_win + 1'b1;
        if (w_nop) begin
          r_result <= '0;
          r_err    <= 1'b0;
        end
      end
      if (r_state == S_BUSY) begin
        r_cnt <= r_cnt + 8'd1;
        if (alu_done) begin
          r_result <= alu_result;
          r_err    <= 1'b0;
        end else if (w_tmo) begin
          r_result <= 16'hFFFF;
          r_err    <= 1'b1;
        end
      end
      if (r_state == S_RESP) r_cnt <= '0;
    end
  end
  assign req_ready   = w_accept ? NUM_REQ'(1) << w_win : '0;
  assign rsp_valid   = r_state == S_RESP ? NUM_REQ'(1) << r_owner : '0;
  assign rsp_result  = r_result;
  assign rsp_err     = r_err;
  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign alu_op      = r_op;
  assign alu_start   = r_state == S_BUSY;
  assign alu_reset_n = ~reset_i;
`ifdef TINYALU_ARB_STATS_EN
  logic [31:0] r_ops, r_busy;
  logic [7:0] r_tmos;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_ops  <= '0;
      r_busy <= '0;
      r_tmos <= '0;
    end else if (r_state == S_BUSY) begin
      r_busy <= r_busy + 32'd1;
      if (w_next == S_RESP) r_ops <= r_ops + 32'd1;
      if (!alu_done && w_tmo && r_tmos != 8'hFF) r_tmos <= r_tmos + 8'd1;
    end
  end
  assign stat_ops      = r_ops;
  assign stat_busy     = r_busy;
  assign stat_timeouts = r_tmos;
`endif
endmodule

// File: tb/tb_tinyalu_arbiter.sv
// tb_tinyalu_arbiter: directed vectors against tinyalu_arbiter with a cycle-accurate tinyalu model
module tb_tinyalu_arbiter;
  logic clk_i = 1'b0;
  logic reset_i;
  logic [3:0] req_valid, req_ready, rsp_valid;
  logic [31:0] req_a, req_b;
  logic [11:0] req_op;
  logic [15:0] rsp_result;
  logic rsp_err, alu_start, alu_reset_n;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic alu_done = 1'b0;
  logic [15:0] alu_result = '0;
  logic alu_dead = 1'b0;
  logic [2:0] m_cnt = '0;
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] rr_exp [4];
`ifdef TINYALU_ARB_STATS_EN
  logic [31:0] stat_ops, stat_busy;
  logic [7:0] stat_timeouts;
`endif
  tinyalu_arbiter dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_start(alu_start), .alu_reset_n(alu_reset_n),
    .alu_done(alu_done), .alu_result(alu_result)
`ifdef TINYALU_ARB_STATS_EN
    , .stat_ops(stat_ops), .stat_busy(stat_busy), .stat_timeouts(stat_timeouts)
`endif
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) begin
    if (!alu_start) begin
      m_cnt    <= '0;
      alu_done <= 1'b0;
    end else begin
      m_cnt    <= m_cnt + 3'd1;
      alu_done <= !alu_dead && (alu_op[2] ? m_cnt == 3'd3 : m_cnt == 3'd0);
      alu_result <= alu_op[2] ? 16'(alu_a) * 16'(alu_b) :
                    alu_op == 3'b001 ? 16'(alu_a) + 16'(alu_b) :
                    alu_op == 3'b010 ? 16'(alu_a & alu_b) : 16'(alu_a ^ alu_b);
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask
  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
    req_op[3*i +: 3] = op;
  endtask
  initial begin
    reset_i = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    rr_exp[0] = 16'h0030;
    rr_exp[1] = 16'h000A;
    rr_exp[2] = 16'h0081;
    rr_exp[3] = 16'h0010;
    step(2);
    chk("rst_start", alu_start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_reset_n", alu_reset_n, 0);
    reset_i = 1'b0;
    #1;
    chk("reset_n_high", alu_reset_n, 1);
    chk("idle_ready", req_ready, 0);
    set_req(0, 8'd200, 8'd100, 3'b001);
    req_valid = 4'b0001;
    #1;
    chk("add_ready", req_ready, 4'b0001);
    step(1);
    req_valid = '0;
    chk("add_start", alu_start, 1);
    chk("add_alu_a", alu_a, 8'd200);
    chk("add_alu_b", alu_b, 8'd100);
    chk("add_alu_op", alu_op, 3'b001);
    step(1);
    chk("add_no_rsp_t2", rsp_valid, 0);
    step(1);
    chk("add_rsp_valid", rsp_valid, 4'b0001);
    chk("add_result", rsp_result, 16'd300);
    chk("add_err", rsp_err, 0);
    chk("add_start_low", alu_start, 0);
    step(1);
    chk("add_rsp_pulse", rsp_valid, 0);
    set_req(2, 8'hFF, 8'hFF, 3'b100);
    req_valid = 4'b0100;
    #1;
    chk("mul_ready", req_ready, 4'b0100);
    chk("mul_start_t0", alu_start, 0);
    step(1);
    req_valid = '0;
    for (int k = 1; k <= 5; k++) begin
      chk("mul_start", alu_start, 1);
      chk("mul_no_rsp", rsp_valid, 0);
      step(1);
    end
    chk("mul_rsp_valid", rsp_valid, 4'b0100);
    chk("mul_result", rsp_result, 16'hFE01);
    chk("mul_err", rsp_err, 0);
    chk("mul_start_t6", alu_start, 0);
    step(1);
    set_req(1, 8'd5, 8'd7, 3'b000);
    req_valid = 4'b0010;
    #1;
    chk("nop_ready", req_ready, 4'b0010);
    step(1);
    req_valid = '0;
    chk("nop_rsp_valid", rsp_valid, 4'b0010);
    chk("nop_result", rsp_result, 0);
    chk("nop_err", rsp_err, 0);
    chk("nop_start", alu_start, 0);
    step(1);
    chk("nop_start_after", alu_start, 0);
    reset_i = 1'b1;
    step(1);
    reset_i = 1'b0;
    set_req(0, 8'hF0, 8'h3C, 3'b010);
    set_req(1, 8'hAA, 8'h0F, 3'b010);
    set_req(2, 8'hFF, 8'h81, 3'b010);
    set_req(3, 8'h12, 8'h34, 3'b010);
    req_valid = 4'b1111;
    #1;
    for (int g = 0; g < 5; g++) begin
      chk("rr_grant", req_ready, 32'd1 << (g % 4));
      step(3);
      chk("rr_hold_ready", req_ready, 0);
      chk("rr_rsp_valid", rsp_valid, 32'd1 << (g % 4));
      chk("rr_result", rsp_result, rr_exp[g % 4]);
      if (g == 4) req_valid = '0;
      step(1);
    end
    alu_dead = 1'b1;
    set_req(3, 8'd1, 8'd2, 3'b011);
    req_valid = 4'b1000;
    #1;
    chk("tmo_ready", req_ready, 4'b1000);
    step(1);
    req_valid = '0;
    step(14);
    chk("tmo_no_rsp_t15", rsp_valid, 0);
    chk("tmo_start_t15", alu_start, 1);
    step(1);
    chk("tmo_rsp_valid", rsp_valid, 4'b1000);
    chk("tmo_result", rsp_result, 16'hFFFF);
    chk("tmo_err", rsp_err, 1);
    chk("tmo_start_low", alu_start, 0);
    alu_dead = 1'b0;
    step(1);
    set_req(3, 8'h0F, 8'h3C, 3'b011);
    req_valid = 4'b1000;
    #1;
    chk("post_tmo_ready", req_ready, 4'b1000);
    step(1);
    req_valid = '0;
    step(2);
    chk("post_tmo_rsp", rsp_valid, 4'b1000);
    chk("post_tmo_result", rsp_result, 16'h0033);
    chk("post_tmo_err", rsp_err, 0);
    step(1);
    set_req(0, 8'd3, 8'd5, 3'b100);
    req_valid = 4'b0001;
    #1;
    chk("rmul_ready", req_ready, 4'b0001);
    step(1);
    req_valid = '0;
    step(2);
    reset_i = 1'b1;
    step(1);
    chk("rmul_start", alu_start, 0);
    chk("rmul_rsp", rsp_valid, 0);
    reset_i = 1'b0;
    set_req(1, 8'hFF, 8'h01, 3'b001);
    req_valid = 4'b0010;
    #1;
    chk("rmul_idle_ready", req_ready, 4'b0010);
    step(1);
    req_valid = '0;
    chk("rmul_no_rsp_t1", rsp_valid, 0);
    step(1);
    chk("rmul_no_rsp_t2", rsp_valid, 0);
    step(1);
    chk("radd_rsp", rsp_valid, 4'b0010);
    chk("radd_result", rsp_result, 16'h0100);
    chk("radd_err", rsp_err, 0);
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
